mouse_packet_tracker: RTL and testbench
=======================================

# mouse_packet_tracker

Converts the PS/2 mouse byte stream into screen-space cursor state for the whack-an-engineer display path. It sits directly downstream of the PS/2 byte receiver, which delivers one validated byte per strobe. It assembles standard 3-byte mouse packets, checks their framing, accumulates the X/Y deltas into clamped 9-bit coordinates, and exports the left-button state and FSM state. The coordinates feed the HEX debug display and the game's hit logic.

## Interface
- `X_MAX`, 319: largest legal x coordinate.
- `Y_MAX`, 239: largest legal y coordinate.
- `X_INIT`, 160: x after reset.
- `Y_INIT`, 120: y after reset.
- `TIMEOUT_CYCLES`, 1000000: idle cycles (20 ms at 50 MHz) tolerated mid-packet.
- `CLOCK_50` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `byte_valid` in 1: one-cycle strobe; `byte_data` is valid this cycle.
- `byte_data` in 8: received PS/2 byte.
- `enable` in 1: when high, position updates are applied.
- `leftclick` out 1: left-button state from the last accepted packet.
- `x` out 9: cursor x, range 0..X_MAX.
- `y` out 9: cursor y, range 0..Y_MAX, 0 = top.
- `cState` out 2: current FSM state encoding.
- `packet_valid` out 1: one-cycle pulse per accepted packet.
- `sync_err` out 1: one-cycle pulse on mid-packet timeout.

## Operation
- FSM states:
  - `WAIT_B0` = 2'b00.
  - `WAIT_B1` = 2'b01.
  - `WAIT_B2` = 2'b10.
  - `UPDATE` = 2'b11.
- `cState` is the FSM state register.
- Byte 0 layout:
  - bit0: left button. bit1: right button. bit2: middle button.
  - bit3: always 1.
  - bit4: X sign. bit5: Y sign.
  - bit6: X overflow. bit7: Y overflow.
- Byte 1 is the X magnitude. Byte 2 is the Y magnitude.
- `WAIT_B0`:
  - On `byte_valid` with bit3=1: latch byte 0 and go to `WAIT_B1`.
  - On `byte_valid` with bit3=0: discard the byte and stay.
- `WAIT_B1`: on `byte_valid`, latch dx and go to `WAIT_B2`.
- `WAIT_B2`: on `byte_valid`, latch dy and go to `UPDATE`.
- `UPDATE` lasts exactly one cycle, then normally returns to `WAIT_B0`. If `byte_valid` is high during `UPDATE`, that byte is evaluated as byte 0 using the `WAIT_B0` rules.
- Deltas:
  - Each delta is `{sign, magnitude}`, a 9-bit two's-complement value (-256..255).
  - If an axis's overflow bit is set, that axis delta is forced to 0.
- Coordinate update:
  - x_new = x + dx.
  - y_new = y − dy (PS/2 positive Y means up; screen y grows down).
  - Both are computed in 11-bit signed arithmetic.
  - Results below 0 are clamped to 0; results above the axis MAX are clamped to MAX.
- Outputs updated in `UPDATE`:
  - `leftclick` ← byte0[0], always.
  - x, y are written only when `enable`=1; otherwise they hold.
  - `packet_valid` pulses regardless of `enable`.
- Mid-packet timeout:
  - An idle counter runs in `WAIT_B1` and `WAIT_B2` and clears on every `byte_valid`.
  - When it reaches TIMEOUT_CYCLES−1, the FSM returns to `WAIT_B0` and `sync_err` pulses.
  - The partial packet is dropped; x, y and `leftclick` are unchanged.

## Timing
- Reset values (asserted asynchronously, released synchronously by the `resetn` rise):
  - `x`=X_INIT, `y`=Y_INIT.
  - `leftclick`=0, `cState`=2'b00.
  - `packet_valid`=0, `sync_err`=0.
  - Idle counter = 0.
- Latency:
  - The third byte is sampled at edge k; `cState`=11 follows edge k.
  - `x`, `y`, `leftclick` and `packet_valid` update at edge k+1.
  - `packet_valid` is high for exactly one cycle.
- No handshake back to the receiver. Every strobe is consumed in the same cycle; none is dropped except a byte 0 with bit3 cleared.
- `resetn` low mid-packet aborts the packet immediately. Partial bytes are never applied.
- The timeout and an arriving byte can coincide on the terminal count. The byte wins: it is accepted normally and no `sync_err` is raised.

## Configuration
- `MOUSE_TRACKER_TIMEOUT_EN`:
  - Defined: the idle counter and `sync_err` pulses are implemented as described.
  - Undefined: the counter is removed, `sync_err` is tied to 0, and the FSM waits indefinitely in `WAIT_B1`/`WAIT_B2`.

## Structure
- `mouse_pkg` holds:
  - The 2-bit state encodings (`WAIT_B0`..`UPDATE`).
  - The byte-0 bit-index constants.
  - The default screen constants (320×240, centre 160/120).
- One sub-module, `mouse_axis_accum`: a signed 9-bit delta plus 9-bit position, saturating to 0..MAX, with an overflow-zero input. It is instantiated once for x and once for y; y is fed the negated delta.

## Test plan
- Valid packet from reset: bytes 0x09, 0x05, 0x03 → x=165, y=117, `leftclick`=1, one `packet_valid` pulse one cycle after the third byte.
- Negative clamp: starting at x=2, bytes 0x18, 0xF0, 0x00 → x=0, y unchanged, `leftclick`=0.
- Framing: byte 0x05 (bit3 clear) → `cState` stays 00, nothing changes. A following packet 0x08, 0x01, 0x00 then gives x+1.
- Timeout: bytes 0x08, 0x10, then TIMEOUT_CYCLES idle cycles → `sync_err` pulse, `cState`=00, x and y unchanged.
- Overflow: bytes 0x48, 0x7F, 0x01 → x unchanged, y decremented by 1.
- Disabled: `enable`=0 with bytes 0x09, 0x05, 0x03 → `leftclick`=1 and `packet_valid` pulses, x and y hold at reset values.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse packet tracker: FSM encodings,
// byte-0 field positions and default screen geometry.
package mouse_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'b00,
        WAIT_B1 = 2'b01,
        WAIT_B2 = 2'b10,
        UPDATE  = 2'b11
    } state_t;

    // Byte 0 bit positions
    localparam int B0_LEFT    = 0;
    localparam int B0_RIGHT   = 1;
    localparam int B0_MIDDLE  = 2;
    localparam int B0_ALWAYS1 = 3;
    localparam int B0_XSIGN   = 4;
    localparam int B0_YSIGN   = 5;
    localparam int B0_XOVF    = 6;
    localparam int B0_YOVF    = 7;

    localparam int SCREEN_W     = 320;
    localparam int SCREEN_H     = 240;
    localparam int X_MAX_DEF    = SCREEN_W - 1;
    localparam int Y_MAX_DEF    = SCREEN_H - 1;
    localparam int X_INIT_DEF   = SCREEN_W / 2;
    localparam int Y_INIT_DEF   = SCREEN_H / 2;
    localparam int TIMEOUT_DEF  = 1000000;

endpackage

// File: rtl/mouse_axis_accum.sv
// One cursor axis: adds a signed delta to a 9-bit position and saturates
// the result into 0..MAX. A set overflow flag turns the delta into zero.
module mouse_axis_accum #(
    parameter int MAX = 319
) (
    input  logic [8:0]        pos,
    input  logic signed [9:0] delta,
    input  logic              ovf_zero,
    output logic [8:0]        pos_next
);

    localparam logic signed [10:0] MAX_S = 11'(MAX);

    logic signed [10:0] sum;

    // 10-bit delta so the y axis can carry +256 after negating -256
    always_comb begin
        sum      = $signed({2'b00, pos}) + (ovf_zero ? 11'sd0 : $signed({delta[9], delta}));
        pos_next = pos;
        if (sum < 11'sd0) begin
            pos_next = 9'd0;
        end else if (sum > MAX_S) begin
            pos_next = MAX_S[8:0];
        end else begin
            pos_next = sum[8:0];
        end
    end

endmodule

// File: rtl/mouse_packet_tracker.sv
// Assembles 3-byte PS/2 mouse packets into clamped cursor x/y and left-button
// state. Define MOUSE_TRACKER_TIMEOUT_EN to enable the mid-packet idle timeout.
module mouse_packet_tracker
    import mouse_pkg::*;
#(
    parameter int X_MAX          = X_MAX_DEF,
    parameter int Y_MAX          = Y_MAX_DEF,
    parameter int X_INIT         = X_INIT_DEF,
    parameter int Y_INIT         = Y_INIT_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       enable,
    output logic       leftclick,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic [1:0] cState,
    output logic       packet_valid,
    output logic       sync_err
);

    state_t      state;
    logic        b0_left;
    logic        b0_xsign;
    logic        b0_ysign;
    logic        b0_xovf;
    logic        b0_yovf;
    logic [7:0]  dx_mag;
    logic [7:0]  dy_mag;
    logic        timeout_hit;
    logic signed [9:0] dx_ext;
    logic signed [9:0] dy_neg;
    logic [8:0]  x_next;
    logic [8:0]  y_next;
    logic        unused_bits;

    assign cState      = state;
    assign unused_bits = ^byte_data[B0_MIDDLE:B0_RIGHT];

    // PS/2 positive Y is up while screen y grows down, hence the negation
    assign dx_ext = $signed({b0_xsign, b0_xsign, dx_mag});
    assign dy_neg = -$signed({b0_ysign, b0_ysign, dy_mag});

    mouse_axis_accum #(.MAX(X_MAX)) u_x_accum (
        .pos      (x),
        .delta    (dx_ext),
        .ovf_zero (b0_xovf),
        .pos_next (x_next)
    );

    mouse_axis_accum #(.MAX(Y_MAX)) u_y_accum (
        .pos      (y),
        .delta    (dy_neg),
        .ovf_zero (b0_yovf),
        .pos_next (y_next)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state        <= WAIT_B0;
            b0_left      <= 1'b0;
            b0_xsign     <= 1'b0;
            b0_ysign     <= 1'b0;
            b0_xovf      <= 1'b0;
            b0_yovf      <= 1'b0;
            dx_mag       <= 8'd0;
            dy_mag       <= 8'd0;
            leftclick    <= 1'b0;
            x            <= 9'(X_INIT);
            y            <= 9'(Y_INIT);
            packet_valid <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            case (state)
                WAIT_B0: begin
                    if (byte_valid && byte_data[B0_ALWAYS1]) begin
                        b0_left  <= byte_data[B0_LEFT];
                        b0_xsign <= byte_data[B0_XSIGN];
                        b0_ysign <= byte_data[B0_YSIGN];
                        b0_xovf  <= byte_data[B0_XOVF];
                        b0_yovf  <= byte_data[B0_YOVF];
                        state    <= WAIT_B1;
                    end
                end
                WAIT_B1: begin
                    if (byte_valid) begin
                        dx_mag <= byte_data;
                        state  <= WAIT_B2;
                    end else if (timeout_hit) begin
                        state <= WAIT_B0;
                    end
                end
                WAIT_B2: begin
                    if (byte_valid) begin
                        dy_mag <= byte_data;
                        state  <= UPDATE;
                    end else if (timeout_hit) begin
                        state <= WAIT_B0;
                    end
                end
                UPDATE: begin
                    leftclick    <= b0_left;
                    packet_valid <= 1'b1;
                    if (enable) begin
                        x <= x_next;
                        y <= y_next;
                    end
                    // A byte arriving here already belongs to the next packet
                    if (byte_valid && byte_data[B0_ALWAYS1]) begin
                        b0_left  <= byte_data[B0_LEFT];
                        b0_xsign <= byte_data[B0_XSIGN];
                        b0_ysign <= byte_data[B0_YSIGN];
                        b0_xovf  <= byte_data[B0_XOVF];
                        b0_yovf  <= byte_data[B0_YOVF];
                        state    <= WAIT_B1;
                    end else begin
                        state <= WAIT_B0;
                    end
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

`ifdef MOUSE_TRACKER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] idle_cnt;
    logic             waiting;

    assign waiting     = (state == WAIT_B1) || (state == WAIT_B2);
    assign timeout_hit = waiting && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // A byte on the terminal count wins over the timeout
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            idle_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= waiting && !byte_valid && timeout_hit;
            if (!waiting || byte_valid || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign timeout_hit = 1'b0;
    assign sync_err    = 1'b0;
    assign unused_cfg  = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Self-checking bench for mouse_packet_tracker: vector table of packets,
// a packet_valid-driven scoreboard, and hand sequences for timing corners.
module tb_mouse_packet_tracker;

    localparam int T = 40;

    logic       clk;
    logic       resetn;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       enable;
    logic       leftclick;
    logic [8:0] x;
    logic [8:0] y;
    logic [1:0] cState;
    logic       packet_valid;
    logic       sync_err;

    mouse_packet_tracker #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .enable       (enable),
        .leftclick    (leftclick),
        .x            (x),
        .y            (y),
        .cState       (cState),
        .packet_valid (packet_valid),
        .sync_err     (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       en;
        int         ex;
        int         ey;
        logic       el;
    } vec_t;

    vec_t        vecs[14];
    logic [18:0] exp_q[$];
    logic [18:0] sb_e;
    int          total;
    int          passed;
    int          pulses;
    int          pushed;
    int          ex;
    int          ey;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Driver: called right after a falling edge, returns after the next one
    task automatic drive_byte(input logic [7:0] d);
        byte_valid = 1'b1;
        byte_data  = d;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pkt(input int px, input int py, input logic pl);
        exp_q.push_back({pl, 9'(px), 9'(py)});
        pushed++;
    endtask

    // Scoreboard: every packet_valid pulse consumes one expected record
    always @(negedge clk) begin
        if (resetn && packet_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_packet_valid", 1, 0);
            end else begin
                sb_e = exp_q.pop_front();
                check("pkt_x", int'(x), int'(sb_e[17:9]));
                check("pkt_y", int'(y), int'(sb_e[8:0]));
                check("pkt_leftclick", int'(leftclick), int'(sb_e[18]));
            end
        end
    end

    initial begin
        total = 0; passed = 0; pulses = 0; pushed = 0;
        resetn = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; enable = 1'b1;

        //              b0     b1     b2    en    x    y   left
        vecs[0]  = '{8'h09, 8'h05, 8'h03, 1'b1, 165, 117, 1'b1};
        vecs[1]  = '{8'h18, 8'hF0, 8'h00, 1'b1, 149, 117, 1'b0};
        vecs[2]  = '{8'h48, 8'h7F, 8'h01, 1'b1, 149, 116, 1'b0};
        vecs[3]  = '{8'h08, 8'h01, 8'h00, 1'b1, 150, 116, 1'b0};
        vecs[4]  = '{8'h09, 8'h05, 8'h03, 1'b0, 150, 116, 1'b1};
        vecs[5]  = '{8'h28, 8'h00, 8'h80, 1'b1, 150, 239, 1'b0};
        vecs[6]  = '{8'h08, 8'hFF, 8'h00, 1'b1, 319, 239, 1'b0};
        vecs[7]  = '{8'h08, 8'h00, 8'hFF, 1'b1, 319,   0, 1'b0};
        vecs[8]  = '{8'h18, 8'h00, 8'h00, 1'b1,  63,   0, 1'b0};
        vecs[9]  = '{8'h3A, 8'hFE, 8'hFF, 1'b1,  61,   1, 1'b0};
        vecs[10] = '{8'h89, 8'h10, 8'h7F, 1'b1,  77,   1, 1'b1};
        vecs[11] = '{8'hC9, 8'hFF, 8'hFF, 1'b1,  77,   1, 1'b1};
        vecs[12] = '{8'h18, 8'hB5, 8'h00, 1'b1,   2,   1, 1'b0};
        vecs[13] = '{8'h18, 8'hF0, 8'h00, 1'b1,   0,   1, 1'b0};

        idle(3);
        resetn = 1'b1;
        idle(1);

        check("reset_x", int'(x), 160);
        check("reset_y", int'(y), 120);
        check("reset_leftclick", int'(leftclick), 0);
        check("reset_cstate", int'(cState), 0);
        check("reset_packet_valid", int'(packet_valid), 0);
        check("reset_sync_err", int'(sync_err), 0);

        for (int i = 0; i < 14; i++) begin
            enable = vecs[i].en;
            drive_byte(vecs[i].b0);
            idle($urandom_range(0, 2));
            drive_byte(vecs[i].b1);
            idle($urandom_range(0, 2));
            expect_pkt(vecs[i].ex, vecs[i].ey, vecs[i].el);
            drive_byte(vecs[i].b2);
            idle(2);
        end
        enable = 1'b1;
        ex = 0; ey = 1;

        // Latency: UPDATE follows the third byte, outputs one edge later
        drive_byte(8'h08);
        check("lat_cstate_b1", int'(cState), 1);
        drive_byte(8'h01);
        check("lat_cstate_b2", int'(cState), 2);
        ex = ex + 1;
        expect_pkt(ex, ey, 1'b0);
        drive_byte(8'h00);
        check("lat_cstate_update", int'(cState), 3);
        check("lat_pv_early", int'(packet_valid), 0);
        check("lat_x_held", int'(x), ex - 1);
        idle(1);
        check("lat_cstate_back", int'(cState), 0);
        check("lat_pv_pulse", int'(packet_valid), 1);
        idle(1);
        check("lat_pv_one_cycle", int'(packet_valid), 0);

        // Framing: bit3-clear byte is dropped
        drive_byte(8'h05);
        check("frame_cstate", int'(cState), 0);
        check("frame_x", int'(x), ex);
        drive_byte(8'h08);
        drive_byte(8'h01);
        ex = ex + 1;
        expect_pkt(ex, ey, 1'b0);
        drive_byte(8'h00);
        idle(2);

        // Back-to-back: byte 0 of the next packet arrives during UPDATE
        drive_byte(8'h09);
        drive_byte(8'h02);
        ex = ex + 2;
        expect_pkt(ex, ey, 1'b1);
        drive_byte(8'h00);
        drive_byte(8'h08);
        check("b2b_cstate", int'(cState), 1);
        drive_byte(8'h01);
        ex = ex + 1;
        expect_pkt(ex, ey, 1'b0);
        drive_byte(8'h00);
        idle(2);

`ifdef MOUSE_TRACKER_TIMEOUT_EN
        drive_byte(8'h08);
        drive_byte(8'h10);
        idle(T - 1);
        check("to_not_yet_err", int'(sync_err), 0);
        check("to_not_yet_state", int'(cState), 2);
        idle(1);
        check("to_sync_err", int'(sync_err), 1);
        check("to_cstate", int'(cState), 0);
        check("to_x", int'(x), ex);
        check("to_y", int'(y), ey);
        idle(1);
        check("to_err_one_cycle", int'(sync_err), 0);
`else
        drive_byte(8'h08);
        drive_byte(8'h10);
        idle(T);
        check("nto_sync_err", int'(sync_err), 0);
        check("nto_cstate", int'(cState), 2);
        ex = ex + 16;
        expect_pkt(ex, ey, 1'b0);
        drive_byte(8'h00);
        idle(2);
`endif

        // Byte on the terminal idle count is accepted, no sync_err
        drive_byte(8'h08);
        idle(T - 1);
        drive_byte(8'h03);
        check("coinc_cstate", int'(cState), 2);
        check("coinc_sync_err", int'(sync_err), 0);
        ex = ex + 3;
        expect_pkt(ex, ey, 1'b0);
        drive_byte(8'h00);
        idle(2);

        // Asynchronous reset mid-packet discards the partial packet
        drive_byte(8'h09);
        drive_byte(8'h05);
        #3;
        resetn = 1'b0;
        #1;
        check("arst_cstate", int'(cState), 0);
        check("arst_x", int'(x), 160);
        check("arst_y", int'(y), 120);
        @(negedge clk);
        resetn = 1'b1;
        drive_byte(8'h03);
        check("arst_stray_cstate", int'(cState), 0);
        idle(2);
        check("arst_final_x", int'(x), 160);
        check("arst_final_leftclick", int'(leftclick), 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("pulse_count", pulses, pushed);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
